// File: rtl/mosaic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : mosaic_pkg                                                |
// | Purpose   : Shared widths, FSM/pattern/channel enums and the CFA      |
// |             channel-select helper for the remosaic datapath.          |
// | Revision  : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package mosaic_pkg;

  localparam int ADDR_W = 16;
  localparam int PIX_W  = 8;
  localparam int H_W    = 8;
  localparam int W_W    = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RGGB = 2'd0,
    GRBG = 2'd1,
    GBRG = 2'd2,
    BGGR = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } chan_e;

  // Off-diagonal sites of RGGB/BGGR and diagonal sites of GRBG/GBRG are green;
  // the remaining two sites of each 2x2 tile carry R and B.
  function automatic chan_e chan_sel(input pattern_e pat, input logic row_par,
                                     input logic col_par);
    chan_e ch;
    ch = CH_G;
    if (row_par == col_par) begin
      case (pat)
        RGGB:    ch = row_par ? CH_B : CH_R;
        BGGR:    ch = row_par ? CH_R : CH_B;
        default: ch = CH_G;
      endcase
    end else begin
      case (pat)
        GRBG:    ch = row_par ? CH_B : CH_R;
        GBRG:    ch = row_par ? CH_R : CH_B;
        default: ch = CH_G;
      endcase
    end
    return ch;
  endfunction

endpackage
`default_nettype wire

// File: rtl/remosaic_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : remosaic_if                                               |
// | Purpose   : Start/config, channel-read and Bayer-write buses of the   |
// |             remosaic block. slave = the block, master = its driver.   |
// | Revision  : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface remosaic_if;
  import mosaic_pkg::*;

  logic              in_en;
  logic [H_W-1:0]    height;
  logic [W_W-1:0]    width;
  logic [1:0]        pattern;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_g;
  logic [ADDR_W-1:0] addr_b;
  logic [PIX_W-1:0]  rdata_r;
  logic [PIX_W-1:0]  rdata_g;
  logic [PIX_W-1:0]  rdata_b;
  logic              wr_bayer;
  logic [ADDR_W-1:0] addr_bayer;
  logic [PIX_W-1:0]  wdata_bayer;
  logic              busy;
  logic              done;

  modport slave (
    input  in_en, height, width, pattern, rdata_r, rdata_g, rdata_b,
    output addr_r, addr_g, addr_b, wr_bayer, addr_bayer, wdata_bayer, busy, done
  );

  modport master (
    output in_en, height, width, pattern, rdata_r, rdata_g, rdata_b,
    input  addr_r, addr_g, addr_b, wr_bayer, addr_bayer, wdata_bayer, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/remosaic_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : remosaic_addr_gen                                         |
// | Purpose   : Row/column/linear pixel counters with raster wrap and a   |
// |             last-pixel flag. Linear address is a plain incrementer.   |
// | Revision  : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module remosaic_addr_gen
  import mosaic_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              adv_i,
  input  logic [H_W-1:0]    height_i,
  input  logic [W_W-1:0]    width_i,
  output logic              row_par_o,
  output logic              col_par_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [H_W-1:0]    row_q, row_d;
  logic [W_W-1:0]    col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [H_W-1:0]    w_row_max;
  logic [W_W-1:0]    w_col_max;
  logic              w_col_last;

  assign w_row_max  = height_i - 8'd1;
  assign w_col_max  = width_i - 9'd1;
  assign w_col_last = (col_q == w_col_max);

  assign row_par_o = row_q[0];
  assign col_par_o = col_q[0];
  assign addr_o    = addr_q;
  assign last_o    = w_col_last && (row_q == w_row_max);

  // Next-state: clear on frame start, raster-advance one pixel when enabled.
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    addr_d = addr_q;
    if (clear_i) begin
      row_d  = '0;
      col_d  = '0;
      addr_d = '0;
    end else if (adv_i) begin
      addr_d = addr_q + 16'd1;
      if (w_col_last) begin
        col_d = '0;
        row_d = row_q + 8'd1;
      end else begin
        col_d = col_q + 9'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      addr_q <= addr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/remosaic.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : remosaic                                                  |
// | Purpose   : Re-mosaics full-resolution R/G/B channel buffers into a   |
// |             single-plane Bayer image, one pixel per cycle.            |
// | Options   : REMOSAIC_CHECKSUM_EN adds a modulo-2^16 sum of all        |
// |             written pixels on the checksum port.                      |
// | Revision  : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module remosaic
  import mosaic_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  remosaic_if.slave   bus
`ifdef REMOSAIC_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  state_e            state_q, state_d;
  logic [H_W-1:0]    height_q;
  logic [W_W-1:0]    width_q;
  pattern_e          pattern_q;
  logic              wr_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [PIX_W-1:0]  wdata_q;

  logic              w_start;
  logic              w_adv;
  logic              w_row_par;
  logic              w_col_par;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr;
  chan_e             w_sel;
  logic [PIX_W-1:0]  w_pix;

  assign w_start = (state_q == IDLE) && bus.in_en;
  assign w_adv   = (state_q == SCAN) && !w_last;

  remosaic_addr_gen u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (w_start),
    .adv_i     (w_adv),
    .height_i  (height_q),
    .width_i   (width_q),
    .row_par_o (w_row_par),
    .col_par_o (w_col_par),
    .addr_o    (w_addr),
    .last_o    (w_last)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; an empty frame skips straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.in_en) begin
          if ((bus.height == '0) || (bus.width == '0)) state_d = DONE;
          else                                         state_d = SCAN;
        end
      end
      SCAN:    if (w_last) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame geometry and CFA order are captured once per start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      height_q  <= '0;
      width_q   <= '0;
      pattern_q <= RGGB;
    end else if (w_start) begin
      height_q  <= bus.height;
      width_q   <= bus.width;
      pattern_q <= pattern_e'(bus.pattern);
    end
  end

  // Pick the channel that owns the current Bayer site.
  always_comb begin
    w_sel = chan_sel(pattern_q, w_row_par, w_col_par);
    case (w_sel)
      CH_R:    w_pix = bus.rdata_r;
      CH_B:    w_pix = bus.rdata_b;
      default: w_pix = bus.rdata_g;
    endcase
  end

  // Write port registers: every SCAN cycle becomes one write next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wr_q <= (state_q == SCAN);
      if (state_q == SCAN) begin
        waddr_q <= w_addr;
        wdata_q <= w_pix;
      end
    end
  end

`ifdef REMOSAIC_CHECKSUM_EN
  logic [15:0] checksum_q;

  // Running sum of presented writes; settles by the DONE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        checksum_q <= '0;
    else if (w_start) checksum_q <= '0;
    else if (wr_q)    checksum_q <= checksum_q + 16'(wdata_q);
  end

  assign checksum = checksum_q;
`endif

  assign bus.addr_r      = w_addr;
  assign bus.addr_g      = w_addr;
  assign bus.addr_b      = w_addr;
  assign bus.wr_bayer    = wr_q;
  assign bus.addr_bayer  = waddr_q;
  assign bus.wdata_bayer = wdata_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_remosaic.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_remosaic                                               |
// | Purpose   : Self-checking bench for remosaic. Channel buffers are     |
// |             arrays; expected Bayer output comes from the CFA pattern  |
// |             name spelled out per 2x2 tile.                            |
// | Options   : REMOSAIC_CHECKSUM_EN also checks the checksum port.       |
// | Revision  : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_remosaic;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   passes = 0;
  int   total  = 0;

  logic [7:0] mem_r [1024];
  logic [7:0] mem_g [1024];
  logic [7:0] mem_b [1024];
  string      pstr  [4] = '{"RGGB", "GRBG", "GBRG", "BGGR"};

  remosaic_if bus ();

`ifdef REMOSAIC_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  remosaic dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus)
`ifdef REMOSAIC_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  always #5 clk = ~clk;

  // Channel buffers answer combinationally.
  always_comb begin
    bus.rdata_r = mem_r[bus.addr_r[9:0]];
    bus.rdata_g = mem_g[bus.addr_g[9:0]];
    bus.rdata_b = mem_b[bus.addr_b[9:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected Bayer value of linear pixel n: the pattern string lists the
  // channel letters of a 2x2 tile in raster order.
  function automatic logic [7:0] exp_pix(input int n, input int w, input int pat);
    string s;
    byte   ch;
    int    r, c;
    r  = n / w;
    c  = n % w;
    s  = pstr[pat];
    ch = s[(r % 2) * 2 + (c % 2)];
    if (ch == "R")      return mem_r[n];
    else if (ch == "B") return mem_b[n];
    else                return mem_g[n];
  endfunction

  // Starts a frame and checks every cycle until back in IDLE.
  // extra_k: cycle index at which in_en is pulsed again (0 = never).
  // reset_k: cycle index at which reset is asserted mid-frame (0 = never).
  task automatic run_frame(input int h, input int w, input int pat,
                           input int extra_k, input int reset_k);
    int n_pix, klast, sum;
    bit exp_wr, exp_done, exp_busy;
    n_pix = h * w;
    klast = (n_pix == 0) ? 2 : n_pix + 3;
    sum   = 0;
    @(negedge clk);
    bus.height  = 8'(h);
    bus.width   = 9'(w);
    bus.pattern = 2'(pat);
    bus.in_en   = 1'b1;
    @(negedge clk);
    bus.in_en = 1'b0;
    for (int k = 1; k <= klast; k++) begin
      if (k == reset_k) begin
        reset = 1'b1;
        #1;
        check("rst_wr",    32'(bus.wr_bayer),    32'd0);
        check("rst_waddr", 32'(bus.addr_bayer),  32'd0);
        check("rst_wdata", 32'(bus.wdata_bayer), 32'd0);
        check("rst_raddr", 32'(bus.addr_r),      32'd0);
        check("rst_busy",  32'(bus.busy),        32'd0);
        check("rst_done",  32'(bus.done),        32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_wr",   32'(bus.wr_bayer), 32'd0);
        check("post_rst_busy", 32'(bus.busy),     32'd0);
        return;
      end
      exp_wr   = (n_pix > 0) && (k >= 2) && (k <= n_pix + 1);
      exp_done = (n_pix == 0) ? (k == 1) : (k == n_pix + 2);
      exp_busy = (n_pix == 0) ? (k == 1) : (k <= n_pix + 2);
      check("wr_bayer", 32'(bus.wr_bayer), 32'(exp_wr));
      if (exp_wr) begin
        check("addr_bayer",  32'(bus.addr_bayer),  32'(k - 2));
        check("wdata_bayer", 32'(bus.wdata_bayer), 32'(exp_pix(k - 2, w, pat)));
        sum += exp_pix(k - 2, w, pat);
      end
      if ((n_pix > 0) && (k <= n_pix)) begin
        check("addr_r", 32'(bus.addr_r), 32'(k - 1));
        check("addr_g", 32'(bus.addr_g), 32'(k - 1));
        check("addr_b", 32'(bus.addr_b), 32'(k - 1));
      end
      check("done", 32'(bus.done), 32'(exp_done));
      check("busy", 32'(bus.busy), 32'(exp_busy));
      bus.in_en = (k == extra_k);
      @(negedge clk);
    end
    bus.in_en = 1'b0;
`ifdef REMOSAIC_CHECKSUM_EN
    check("checksum", 32'(checksum), 32'(sum % 65536));
`endif
  endtask

  initial begin
    bus.in_en   = 1'b0;
    bus.height  = '0;
    bus.width   = '0;
    bus.pattern = '0;
    for (int i = 0; i < 1024; i++) begin
      mem_r[i] = 8'h10;
      mem_g[i] = 8'h20;
      mem_b[i] = 8'h30;
    end
    repeat (2) @(negedge clk);
    check("reset_wr",    32'(bus.wr_bayer),    32'd0);
    check("reset_busy",  32'(bus.busy),        32'd0);
    check("reset_done",  32'(bus.done),        32'd0);
    check("reset_waddr", 32'(bus.addr_bayer),  32'd0);
    check("reset_wdata", 32'(bus.wdata_bayer), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_wr", 32'(bus.wr_bayer), 32'd0);

    // 4x4 RGGB with constant channels.
    run_frame(4, 4, 0, 0, 0);

    // 3x5 BGGR with address-derived channel values.
    for (int i = 0; i < 1024; i++) begin
      mem_r[i] = 8'(i);
      mem_g[i] = 8'(i + 64);
      mem_b[i] = 8'(i + 128);
    end
    run_frame(3, 5, 3, 0, 0);

    // Single-column frame and empty frames.
    run_frame(3, 1, 1, 0, 0);
    run_frame(0, 4, 0, 0, 0);
    run_frame(4, 0, 2, 0, 0);

    // Reset in cycle T+5, then a full frame afterwards.
    run_frame(4, 4, 0, 0, 5);
    run_frame(4, 4, 0, 0, 0);

    // in_en during SCAN is ignored.
    run_frame(4, 4, 1, 4, 0);

    // Randomized frames and channel data.
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 1024; i++) begin
        mem_r[i] = 8'($urandom);
        mem_g[i] = 8'($urandom);
        mem_b[i] = 8'($urandom);
      end
      run_frame(int'($urandom_range(1, 8)), int'($urandom_range(1, 12)),
                int'($urandom_range(0, 3)), 0, 0);
    end

`ifdef REMOSAIC_CHECKSUM_EN
    for (int i = 0; i < 1024; i++) begin
      mem_r[i] = 8'hFF;
      mem_g[i] = 8'hFF;
      mem_b[i] = 8'hFF;
    end
    run_frame(16, 16, 0, 0, 0);
    check("checksum_ff", 32'(checksum), 32'h0000FF00);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire
